// File: rtl/btn_conditioner.sv
// ============================================================================
// btn_conditioner: 2-flop synchronizer, per-button debounce FSM, single-clock
// press enable and auto-repeat enable for the board pushbuttons.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_conditioner #(
  parameter int N_BTN         = 5,
  parameter int DB_COUNT      = 500000,
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter int CNT_W         = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_db,
  output logic [N_BTN-1:0] btn_scen,
  output logic [N_BTN-1:0] btn_mcen
);

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT = 2'd1;
  localparam logic [1:0] ST_PRESSED    = 2'd2;
  localparam logic [1:0] ST_REL_WAIT   = 2'd3;

  localparam logic [CNT_W-1:0] C_DB_LAST   = CNT_W'(DB_COUNT - 1);
  localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    logic [1:0]       sync_q, sync_d;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic             phase_q, phase_d;
    logic             db_q, db_d;
    logic             scen_q, scen_d;
    logic             mcen_q, mcen_d;
    logic             s;
    logic             press;
    logic             rpt;

    assign s      = sync_q[1];
    assign sync_d = {sync_q[0], btn_in[i]};

    // State register: every flop of this button, including the synchronizer
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync_q  <= 2'b00;
        state_q <= ST_IDLE;
        dcnt_q  <= '0;
        hcnt_q  <= '0;
        phase_q <= 1'b0;
        db_q    <= 1'b0;
        scen_q  <= 1'b0;
        mcen_q  <= 1'b0;
      end else begin
        sync_q  <= sync_d;
        state_q <= state_d;
        dcnt_q  <= dcnt_d;
        hcnt_q  <= hcnt_d;
        phase_q <= phase_d;
        db_q    <= db_d;
        scen_q  <= scen_d;
        mcen_q  <= mcen_d;
      end
    end

    // Next-state and counter logic
    always_comb begin
      state_d = state_q;
      dcnt_d  = dcnt_q;
      hcnt_d  = hcnt_q;
      phase_d = phase_q;
      press   = 1'b0;
      rpt     = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (s) begin
            state_d = ST_PRESS_WAIT;
            dcnt_d  = '0;
          end
        end
        ST_PRESS_WAIT: begin
          if (!s) begin
            state_d = ST_IDLE;
            dcnt_d  = '0;
          end else if (dcnt_q == C_DB_LAST) begin
            state_d = ST_PRESSED;
            dcnt_d  = '0;
            hcnt_d  = '0;
            phase_d = 1'b0;
            press   = 1'b1;
          end else begin
            dcnt_d = dcnt_q + C_ONE;
          end
        end
        ST_PRESSED: begin
          if (!s) begin
            state_d = ST_REL_WAIT;
            dcnt_d  = '0;
            hcnt_d  = '0;
          end else if (hcnt_q == (phase_q ? C_REP_LAST : C_HOLD_LAST)) begin
            rpt     = 1'b1;
            hcnt_d  = '0;
            phase_d = 1'b1;
          end else begin
            hcnt_d = hcnt_q + C_ONE;
          end
        end
        ST_REL_WAIT: begin
          // A bounce back to high resumes the hold with a fresh first-repeat delay
          if (s) begin
            state_d = ST_PRESSED;
            dcnt_d  = '0;
            hcnt_d  = '0;
            phase_d = 1'b0;
          end else if (dcnt_q == C_DB_LAST) begin
            state_d = ST_IDLE;
            dcnt_d  = '0;
          end else begin
            dcnt_d = dcnt_q + C_ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          dcnt_d  = '0;
          hcnt_d  = '0;
          phase_d = 1'b0;
        end
      endcase
    end

    // Output logic; en only masks the pulses, never the FSM
    always_comb begin
      db_d   = (state_d == ST_PRESSED) || (state_d == ST_REL_WAIT);
      scen_d = press & en;
      mcen_d = (press | rpt) & en;
    end

    assign btn_db[i]   = db_q;
    assign btn_scen[i] = scen_q;
    assign btn_mcen[i] = mcen_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DB_COUNT=4, HOLD_CYCLES=10, REPEAT_CYCLES=3.
`default_nettype none

module tb_btn_conditioner;

  logic       clk;
  logic       rst;
  logic       en;
  logic [4:0] btn_in;
  logic [4:0] btn_db;
  logic [4:0] btn_scen;
  logic [4:0] btn_mcen;

  int tests;
  int fails;

  btn_conditioner #(
    .N_BTN        (5),
    .DB_COUNT     (4),
    .HOLD_CYCLES  (10),
    .REPEAT_CYCLES(3),
    .CNT_W        (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .btn_in  (btn_in),
    .btn_db  (btn_db),
    .btn_scen(btn_scen),
    .btn_mcen(btn_mcen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int n, input logic [4:0] obs, input logic [4:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s n=%0d: observed %b expected %b", tag, n, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input int n,
                      input logic [4:0] e_scen, input logic [4:0] e_mcen, input logic [4:0] e_db);
    chk({tag, " scen"}, n, btn_scen, e_scen);
    chk({tag, " mcen"}, n, btn_mcen, e_mcen);
    chk({tag, " db"},   n, btn_db,   e_db);
  endtask

  task automatic idle(input int cycles);
    btn_in = 5'b0;
    for (int k = 0; k < cycles; k++) tick();
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    rst    = 1'b0;
    en     = 1'b1;
    btn_in = 5'b0;

    // Reset state
    tick();
    tick();
    chk3("reset", 0, 5'b0, 5'b0, 5'b0);
    rst = 1'b1;

    // Clean press of bit 0: sampled high at edges 1..40, low afterwards
    for (int n = 1; n <= 50; n++) begin
      btn_in[0] = (n <= 40);
      tick();
      chk3("press", n,
           {4'b0, n == 7},
           {4'b0, (n == 7) || (n >= 17 && n <= 42 && (n - 17) % 3 == 0)},
           {4'b0, n >= 7 && n <= 46});
    end
    idle(5);

    // Bounce on bit 2: samples 1,0,1,0 then steady high from edge 5
    for (int n = 1; n <= 24; n++) begin
      btn_in[2] = (n <= 14) && (n != 2) && (n != 4);
      tick();
      chk3("bounce", n,
           {2'b0, n == 11, 2'b0},
           {2'b0, n == 11, 2'b0},
           {2'b0, n >= 11 && n <= 20, 2'b0});
    end
    idle(5);

    // Release bounce on bit 3: low at samples 10 and 11 only, final release at 32
    for (int n = 1; n <= 40; n++) begin
      btn_in[3] = (n <= 31) && (n != 10) && (n != 11);
      tick();
      chk3("relbounce", n,
           {1'b0, n == 7, 3'b0},
           {1'b0, n == 7 || n == 24 || n == 27 || n == 30 || n == 33, 3'b0},
           {1'b0, n >= 7 && n <= 37, 3'b0});
    end
    idle(5);

    // Simultaneous press of bits 1 and 4
    for (int n = 1; n <= 20; n++) begin
      btn_in[1] = (n <= 9);
      btn_in[4] = (n <= 9);
      tick();
      chk3("simul", n,
           (n == 7) ? 5'b10010 : 5'b0,
           (n == 7) ? 5'b10010 : 5'b0,
           (n >= 7 && n <= 15) ? 5'b10010 : 5'b0);
    end
    idle(5);

    // en low through acceptance of bit 0, raised while still held
    for (int n = 1; n <= 20; n++) begin
      btn_in[0] = 1'b1;
      en        = (n >= 9);
      tick();
      chk3("en_mask", n,
           5'b0,
           {4'b0, n == 17 || n == 20},
           {4'b0, n >= 7});
    end

    // Asynchronous reset in the middle of a hold
    #2;
    rst = 1'b0;
    #1;
    chk3("async_rst", 0, 5'b0, 5'b0, 5'b0);
    tick();
    chk3("in_rst", 0, 5'b0, 5'b0, 5'b0);
    rst = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      tick();
      chk3("post_rst", n, {4'b0, n == 7}, {4'b0, n == 7}, {4'b0, n >= 7});
    end
    idle(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
